// File: rtl/calculator_n.sv
// calculator_n: two-operand hex calculator with slider digit entry and a
// multiplexed common-anode 7-segment display.
// Optional build macro CALC_OVF_BLINK_EN: blink the display while an
// overflowed result is shown (8 blank scans, 8 visible scans, repeating).
module calculator_n #(
  parameter int unsigned DIGITS           = 4,
  parameter int unsigned REFRESH_OVERFLOW = 100000,
  parameter int unsigned DB_OVERFLOW      = 1000000,
  parameter int unsigned SLIDER_OVERFLOW  = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button_clr_undeb,
  input  logic              button_ent_undeb,
  input  logic [DIGITS-1:0] sld,
  input  logic [1:0]        sld_op,
  output logic [DIGITS-1:0] digit_select,
  output logic [6:0]        led_select,
  output logic              ovf
);

  localparam int unsigned W   = 4 * DIGITS;
  localparam int unsigned DBW = (DB_OVERFLOW > 0) ? $clog2(DB_OVERFLOW + 1) : 1;
  localparam int unsigned SW  = (SLIDER_OVERFLOW > 1) ? $clog2(SLIDER_OVERFLOW) : 1;
  localparam int unsigned RW  = (REFRESH_OVERFLOW > 1) ? $clog2(REFRESH_OVERFLOW) : 1;
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_OVERFLOW);
  localparam logic [SW-1:0]  SLD_MAX = SW'(SLIDER_OVERFLOW - 1);
  localparam logic [RW-1:0]  REF_MAX = RW'(REFRESH_OVERFLOW - 1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_RES
  } state_t;

  // ---------------------------------------------------------------------
  // Signal declarations
  // ---------------------------------------------------------------------
  logic [1:0]        r_btn_s1, r_btn_s2;   // bit 0 = clear, bit 1 = enter
  logic [DIGITS-1:0] r_sld_s1, r_sld_s2;
  logic [1:0]        r_op_s1,  r_op_s2;

  logic [DBW-1:0]    r_db_cnt [2];
  logic [1:0]        r_db_lvl;
  logic [1:0]        r_db_pulse;
  logic              w_clr, w_ent;

  logic [SW-1:0]     r_sld_cnt [DIGITS];
  logic [DIGITS-1:0] w_inc;

  state_t            r_state;
  logic [W-1:0]      r_a, r_b, r_r;
  logic              r_ovf;

  logic [W:0]        w_sum;
  logic [2*W-1:0]    w_prod;
  logic [W-1:0]      w_res;
  logic              w_res_ovf;

  logic [RW-1:0]     r_ref;
  logic [IW-1:0]     r_idx;
  logic              w_wrap;
  logic [IW-1:0]     w_idx_next;
  logic [W-1:0]      w_val;
  logic [3:0]        w_nib;
  logic              w_blank;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  // Add one (mod 16) to every nibble whose increment bit is set.
  function automatic logic [W-1:0] bump(input logic [W-1:0] v,
                                        input logic [DIGITS-1:0] inc);
    logic [W-1:0] o;
    o = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      o[4*i +: 4] = v[4*i +: 4] + {3'b000, inc[i]};
    end
    return o;
  endfunction

  // Active-low segments {g,f,e,d,c,b,a} for a hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  // Two-flop synchroniser on every raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sld_s1 <= '0;
      r_sld_s2 <= '0;
      r_op_s1  <= '0;
      r_op_s2  <= '0;
    end else begin
      r_btn_s1 <= {button_ent_undeb, button_clr_undeb};
      r_btn_s2 <= r_btn_s1;
      r_sld_s1 <= sld;
      r_sld_s2 <= r_sld_s1;
      r_op_s1  <= sld_op;
      r_op_s2  <= r_op_s1;
    end
  end

  // ---------------------------------------------------------------------
  // Button debounce
  // ---------------------------------------------------------------------
  // Accept a level change after it has been stable long enough; emit a
  // one-cycle pulse on each accepted rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 2; k++) begin
        r_db_cnt[k] <= '0;
      end
      r_db_lvl   <= '0;
      r_db_pulse <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        r_db_pulse[k] <= 1'b0;
        if (r_btn_s2[k] == r_db_lvl[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_MAX) begin
          r_db_lvl[k]   <= r_btn_s2[k];
          r_db_cnt[k]   <= '0;
          r_db_pulse[k] <= r_btn_s2[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DBW'(1);
        end
      end
    end
  end

  assign w_clr = r_db_pulse[0];
  assign w_ent = r_db_pulse[1];

  // ---------------------------------------------------------------------
  // Slider auto-repeat
  // ---------------------------------------------------------------------
  // A held slider requests one digit increment each time its counter wraps.
  always_comb begin
    w_inc = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_inc[i] = r_sld_s2[i] && (r_state != S_RES) && (r_sld_cnt[i] == SLD_MAX);
    end
  end

  // Per-digit repeat counters; idle while the slider is low or in S_RES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        r_sld_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (!r_sld_s2[i] || (r_state == S_RES)) begin
          r_sld_cnt[i] <= '0;
        end else if (r_sld_cnt[i] == SLD_MAX) begin
          r_sld_cnt[i] <= '0;
        end else begin
          r_sld_cnt[i] <= r_sld_cnt[i] + SW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------
  // Result and overflow flag for the synchronised operation select.
  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_prod = (2*W)'(r_a) * (2*W)'(r_b);
    case (r_op_s2)
      2'b00: begin
        w_res     = w_sum[W-1:0];
        w_res_ovf = w_sum[W];
      end
      2'b01: begin
        w_res     = r_a - r_b;
        w_res_ovf = (r_a < r_b);
      end
      2'b10: begin
        w_res     = w_prod[W-1:0];
        w_res_ovf = |w_prod[2*W-1:W];
      end
      default: begin
        w_res     = r_a ^ r_b;
        w_res_ovf = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control state machine and operand registers
  // ---------------------------------------------------------------------
  // Operand entry, result latch and chaining; clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clr) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          r_a <= bump(r_a, w_inc);
          if (w_ent) begin
            r_state <= S_B;
          end
        end
        S_B: begin
          r_b <= bump(r_b, w_inc);
          if (w_ent) begin
            r_r     <= w_res;
            r_ovf   <= w_res_ovf;
            r_state <= S_RES;
          end
        end
        S_RES: begin
          if (w_ent) begin
            r_a     <= r_r;
            r_b     <= '0;
            r_state <= S_A;
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign ovf = r_ovf;

  // ---------------------------------------------------------------------
  // Display multiplexing
  // ---------------------------------------------------------------------
  // Pick the value shown in the current state and the digit about to be lit.
  always_comb begin
    w_wrap     = (r_ref == REF_MAX);
    w_idx_next = r_idx;
    if (w_wrap) begin
      w_idx_next = (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
    end
    case (r_state)
      S_A:     w_val = r_a;
      S_B:     w_val = r_b;
      default: w_val = r_r;
    endcase
    w_nib = 4'(w_val >> (4 * w_idx_next));
  end

`ifdef CALC_OVF_BLINK_EN
  logic       r_blink_armed;
  logic [3:0] r_blink_cnt;

  // Count complete scans while an overflowed result is shown. The partial
  // scan on entry only arms the counter so each phase spans 8 full scans.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_armed <= 1'b0;
      r_blink_cnt   <= '0;
    end else if ((r_state != S_RES) || !r_ovf) begin
      r_blink_armed <= 1'b0;
      r_blink_cnt   <= '0;
    end else if (w_wrap && (r_idx == IDX_MAX)) begin
      if (!r_blink_armed) begin
        r_blink_armed <= 1'b1;
      end else begin
        r_blink_cnt <= r_blink_cnt + 4'd1;
      end
    end
  end

  assign w_blank = (r_state == S_RES) && r_ovf && (!r_blink_armed || !r_blink_cnt[3]);
`else
  assign w_blank = 1'b0;
`endif

  // Refresh timer and registered digit/segment drive, updated together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref        <= '0;
      r_idx        <= '0;
      digit_select <= ~DIGITS'(1);
      led_select   <= 7'b1000000;
    end else begin
      r_ref        <= w_wrap ? '0 : r_ref + RW'(1);
      r_idx        <= w_idx_next;
      digit_select <= w_blank ? '1 : ~(DIGITS'(1) << w_idx_next);
      led_select   <= hex7(w_nib);
    end
  end

endmodule

// File: tb/tb_calculator_n.sv
// Testbench for calculator_n: directed steps from reset followed by random
// operand/operation sequences checked against an arithmetic reference.
module tb_calculator_n;

  logic       clk;
  logic       reset;
  logic       clr_raw;
  logic       ent_raw;
  logic [3:0] sld;
  logic [1:0] sld_op;
  logic [3:0] digit_select;
  logic [6:0] led_select;
  logic       ovf;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  logic [6:0] SEG [16];

  // Reference model state
  int  a_m;
  int  b_m;
  int  r_m;
  bit  ovf_m;

  calculator_n #(
    .DIGITS(4),
    .REFRESH_OVERFLOW(10),
    .DB_OVERFLOW(1),
    .SLIDER_OVERFLOW(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_clr_undeb(clr_raw),
    .button_ent_undeb(ent_raw),
    .sld(sld),
    .sld_op(sld_op),
    .digit_select(digit_select),
    .led_select(led_select),
    .ovf(ovf)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_clr();
    clr_raw = 1'b1; tick(8);
    clr_raw = 1'b0; tick(8);
  endtask

  task automatic press_ent();
    ent_raw = 1'b1; tick(8);
    ent_raw = 1'b0; tick(8);
  endtask

  // Hold slider k for n synchronised cycles.
  task automatic slide(input int k, input int n);
    if (n > 0) begin
      sld[k] = 1'b1;
      tick(n);
      sld[k] = 1'b0;
    end
    tick(4);
  endtask

  // Model: n held cycles give n/3 increments of nibble k, modulo 16.
  function automatic int add_nib(input int v, input int k, input int n);
    int w, nib, nn;
    w   = 1 << (4 * k);
    nib = (v / w) % 16;
    nn  = (nib + n / 3) % 16;
    return v - nib * w + nn * w;
  endfunction

  task automatic enter_value(input int v);
    for (int k = 0; k < 4; k++) slide(k, 3 * ((v >> (4 * k)) & 15));
  endtask

  task automatic calc(input int op, input int a, input int b, output int r, output bit of);
    longint p;
    case (op)
      0: begin r = (a + b) % 65536; of = (a + b) > 65535; end
      1: begin r = (a - b + 65536) % 65536; of = (a < b); end
      2: begin p = longint'(a) * longint'(b); r = int'(p % 65536); of = (p > 65535); end
      default: begin r = a ^ b; of = 1'b0; end
    endcase
  endtask

  // Wait for each digit in turn and compare its segments with the expected nibble.
  task automatic check_disp(input string tag, input int exp);
    for (int j = 0; j < 4; j++) begin
      bit         found;
      logic [3:0] want;
      logic [6:0] obs;
      found = 1'b0;
      want  = ~(4'b0001 << j);
      for (int c = 0; c < 60 && !found; c++) begin
        if (digit_select === want) found = 1'b1;
        else tick(1);
      end
      obs = found ? led_select : 7'h7f;
      check($sformatf("%s_d%0d", tag, j), obs, SEG[(exp >> (4 * j)) & 15]);
    end
  endtask

  initial begin
    SEG = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset   = 1'b1;
    clr_raw = 1'b0;
    ent_raw = 1'b0;
    sld     = 4'b0000;
    sld_op  = 2'b00;

    // Reset state and first refresh step
    #15 reset = 1'b0;
    #1;
    check("rst_dsel", digit_select, 4'b1110);
    check("rst_seg", led_select, 7'b1000000);
    check("rst_ovf", ovf, 1'b0);
    tick(9);
    check("ref_9cyc", digit_select, 4'b1110);
    tick(1);
    check("ref_10cyc", digit_select, 4'b1101);

    // Slider repeat and digit wrap
    slide(0, 9);
    check_disp("sld9", 16'h0003);
    press_clr();
    slide(0, 51);
    check_disp("sld51", 16'h0001);

    // Add, with a one-cycle enter glitch that must be ignored
    press_clr();
    enter_value(16'h0012);
    ent_raw = 1'b1; tick(1);
    ent_raw = 1'b0; tick(6);
    check_disp("glitch", 16'h0012);
    press_ent();
    check_disp("stateB", 16'h0000);
    enter_value(16'h0034);
    sld_op = 2'b00;
    press_ent();
    check_disp("add", 16'h0046);
    check("add_ovf", ovf, 1'b0);

    // Subtract with borrow
    press_clr();
    enter_value(16'h0001);
    press_ent();
    enter_value(16'h0002);
    sld_op = 2'b01;
    press_ent();
    check_disp("sub", 16'hFFFF);
    check("sub_ovf", ovf, 1'b1);

    // Multiply overflow and chaining
    press_clr();
    enter_value(16'h0100);
    press_ent();
    enter_value(16'h0100);
    sld_op = 2'b10;
    press_ent();
    check_disp("mul", 16'h0000);
    check("mul_ovf", ovf, 1'b1);
    press_ent();
    check_disp("chain", 16'h0000);
    check("chain_ovf", ovf, 1'b1);

    // Clear and enter together in S_B: clear wins
    enter_value(16'h00AB);
    check_disp("ce_A", 16'h00AB);
    press_ent();
    enter_value(16'h0005);
    check_disp("ce_B", 16'h0005);
    sld_op  = 2'b00;
    clr_raw = 1'b1;
    ent_raw = 1'b1;
    tick(8);
    clr_raw = 1'b0;
    ent_raw = 1'b0;
    tick(8);
    check_disp("ce_clr", 16'h0000);
    check("ce_ovf", ovf, 1'b0);
    slide(0, 3);
    check_disp("ce_editA", 16'h0001);
    press_ent();
    check_disp("ce_stateB", 16'h0000);

    // Randomized sequences against the arithmetic model
    press_clr();
    a_m   = 0;
    ovf_m = 1'b0;
    for (int it = 0; it < 10; it++) begin
      int n, op;
      for (int k = 0; k < 4; k++) begin
        n = int'($urandom_range(0, 47));
        slide(k, n);
        a_m = add_nib(a_m, k, n);
      end
      check_disp($sformatf("rnd%0d_A", it), a_m);
      press_ent();
      b_m = 0;
      for (int k = 0; k < 4; k++) begin
        n = int'($urandom_range(0, 47));
        slide(k, n);
        b_m = add_nib(b_m, k, n);
      end
      check_disp($sformatf("rnd%0d_B", it), b_m);
      op     = int'($urandom_range(0, 3));
      sld_op = 2'(op);
      press_ent();
      calc(op, a_m, b_m, r_m, ovf_m);
      check_disp($sformatf("rnd%0d_R_op%0d", it, op), r_m);
      check($sformatf("rnd%0d_ovf", it), ovf, ovf_m);
      press_ent();
      a_m = r_m;
      check_disp($sformatf("rnd%0d_chain", it), a_m);
      check($sformatf("rnd%0d_chain_ovf", it), ovf, ovf_m);
      if (it % 3 == 2) begin
        press_clr();
        a_m   = 0;
        ovf_m = 1'b0;
        check_disp($sformatf("rnd%0d_clr", it), a_m);
        check($sformatf("rnd%0d_clr_ovf", it), ovf, ovf_m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
